ahb_sram_con_slave: RTL and testbench
=====================================

Name: ahb_sram_con_slave

Overview:
Parametrised AHB-Lite slave that combines a word-organised SRAM with configurable wait states and a buffered byte console. It replaces the ad-hoc zero-wait memory and console models around CORTEXM0DS. It adds three things those models lack: wait-state insertion, two-cycle ERROR responses for illegal transfers, and a console FIFO with ready/valid drain and back-pressure.

Parameters:
MEM_LOG2, 10, log2 of RAM depth in 32-bit words; RAM occupies bytes 0 .. 4*2^MEM_LOG2-1.
WAIT_STATES, 0, wait cycles (HREADYOUT=0) inserted in every RAM data phase; range 0..15.
CON_ADDR, 32'h40000000, word-aligned byte address of the console register.
CON_LOG2, 2, log2 of console FIFO depth (depth = 2^CON_LOG2 bytes).

Ports:
HCLK  in  1  clock; all state on rising edge.
HRESET  in  1  asynchronous, active-high reset.
HSEL  in  1  slave select.
HADDR  in  32  byte address.
HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ.
HWRITE  in  1  1 = write.
HSIZE  in  3  0=byte, 1=halfword, 2=word.
HWDATA  in  32  write data, valid in data phase.
HREADY  in  1  bus-level ready; address phase accepted only when high.
HRDATA  out  32  read data.
HREADYOUT  out  1  slave ready.
HRESP  out  1  1 = ERROR.
con_valid  out  1  console FIFO not empty.
con_data  out  8  FIFO head byte.
con_ready  in  1  consumer pops head when con_valid & con_ready.

Behaviour:
- Reset: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, FIFO empty, con_valid=0, con_data=0. RAM contents are not reset. Reset asserted mid-transfer aborts it: no RAM write and no FIFO push.
- Address phase accept = HSEL & HREADY & HTRANS[1]. On accept, register addr, write and size, then classify:
  - RAM: addr < 4*2^MEM_LOG2.
  - CON: addr[31:2] == CON_ADDR[31:2].
  - ERR: anything else, or misaligned (halfword with addr[0]=1, word with addr[1:0]!=0), or HSIZE > 2.
- If not accepted (IDLE/BUSY or unselected): next cycle is OKAY, HREADYOUT=1, no side effects.
- FSM states: IDLE, RAMWAIT, CONSTALL, ERR1, ERR2.
  - RAM with WAIT_STATES=0: completes in 1 cycle.
  - RAM with WAIT_STATES>0: enter RAMWAIT. Down-counter loaded with WAIT_STATES; HREADYOUT=0 while count>0; completes on the cycle after count reaches 0. Total data phase = WAIT_STATES+1 cycles.
  - ERR: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE. A new address phase accepted during ERR2 is processed normally.
  - CON write while FIFO full: CONSTALL with HREADYOUT=0 until a pop frees a slot. The push happens in the completing cycle. A pop and a stalled push in the same cycle: the stall ends the following cycle, never the same cycle.
  - Pipelined back-to-back transfers: the next address phase is captured in the completing cycle of the current one (HREADYOUT=1).
- RAM write: byte lanes merged into the stored word on the completing edge per size/addr[1:0]; other lanes are preserved.
- RAM read: HRDATA = full word at addr[MEM_LOG2+1:2], valid when HREADYOUT=1. A read immediately following a write to the same word returns the merged new value.
- CON write: pushes HWDATA byte lane selected by addr[1:0] (byte size), or HWDATA[7:0] (halfword/word).
- CON read: HRDATA = {23'b0, full, 4'b0, occupancy[3:0]}; zero wait states; no side effect.
- FIFO: circular buffer with CON_LOG2+1-bit pointers, wrap at 2^CON_LOG2.
  - con_valid = ~empty; con_data = head.
  - Push and pop in the same cycle when non-empty: occupancy unchanged.
  - Pop when empty: ignored.
- HRDATA = 0 during writes, errors and wait cycles.

Test Plan:
1. WAIT_STATES=2; write word 0xDEADBEEF to 0x10, then read 0x10 -> each data phase has exactly 2 HREADYOUT=0 cycles; read returns 0xDEADBEEF; HRESP=0 throughout.
2. WAIT_STATES=0; word 0x11223344 at 0x20; byte write 0xAA to 0x22, halfword 0x5566 to 0x20, then read 0x20 -> 0x11AA5566; back-to-back pipelined, no wait cycles.
3. Halfword write to 0x21; word read at 4*2^MEM_LOG2 -> each gets ERR1 (HREADYOUT=0, HRESP=1), ERR2 (HREADYOUT=1, HRESP=1); RAM unchanged.
4. CON_LOG2=2, con_ready=0; write bytes 'A','B','C','D','E' to CON_ADDR -> 5th write stalls. Raise con_ready one cycle -> 'A' popped; the 'E' write completes on the next cycle; drained sequence is B,C,D,E.
5. Read CON_ADDR with 3 bytes queued -> HRDATA=0x00000003; with 4 queued -> 0x00000104.
6. Assert HRESET during RAMWAIT of a write to 0x30 -> HREADYOUT=1, HRESP=0 immediately; word at 0x30 unchanged; FIFO empty.

Source files
------------

// File: rtl/ahb_sram_con_slave.sv
// AHB-Lite slave: word SRAM with optional wait states, ERROR responses for
// illegal transfers, and a byte console FIFO drained over ready/valid.
// CON_LOG2 must be at least 1.
module ahb_sram_con_slave #(
  parameter int          MEM_LOG2    = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] CON_ADDR    = 32'h40000000,
  parameter int          CON_LOG2    = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);
  localparam int          AW        = MEM_LOG2 + 2;
  localparam int          DEPTH     = 1 << CON_LOG2;
  localparam logic [32:0] RAM_BYTES = 33'd4 << MEM_LOG2;
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  typedef enum logic [2:0] {IDLE, RAMWAIT, CONSTALL, ERR1, ERR2} state_t;

  state_t             state_q, state_d;
  logic               dph_q, dph_d;     // zero-wait data phase pending in IDLE
  logic               con_q, con_d;     // pending data phase targets the console
  logic               write_q, write_d;
  logic [1:0]         size_q, size_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [CON_LOG2:0]  wr_q, wr_d, rd_q, rd_d;
  logic [31:0]        mem_q [2**MEM_LOG2];
  logic [7:0]         fifo_q [DEPTH];

  logic               accept, bad, is_ram, is_con, done;
  logic               full, empty, push, pop, ram_we;
  logic [CON_LOG2:0]  occ;
  logic [31:0]        occ_ext, con_stat, merged, ram_word;
  logic [3:0]         be;
  logic [7:0]         push_byte;
  logic [AW-3:0]      idx;
  logic               unused_ok;

  assign unused_ok = HTRANS[0];

  assign accept = HSEL & HREADY & HTRANS[1];
  assign bad    = (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) ||
                  (HSIZE > 3'd2);
  assign is_ram = {1'b0, HADDR} < RAM_BYTES;
  assign is_con = HADDR[31:2] == CON_ADDR[31:2];

  assign occ       = wr_q - rd_q;
  assign empty     = occ == '0;
  assign full      = occ == (CON_LOG2+1)'(DEPTH);
  assign occ_ext   = 32'(occ);
  assign con_stat  = {23'b0, full, 4'b0, occ_ext[3:0]};
  assign pop       = ~empty & con_ready;
  assign con_valid = ~empty;
  assign con_data  = empty ? 8'h00 : fifo_q[rd_q[CON_LOG2-1:0]];
  assign push_byte = (size_q == 2'd0) ? HWDATA[{addr_q[1:0], 3'b000} +: 8] : HWDATA[7:0];

  assign idx      = addr_q[AW-1:2];
  assign ram_word = mem_q[idx];

  // Byte-lane enables and merge of write data into the stored word
  always_comb begin
    be = 4'b1111;
    case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    merged = ram_word;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = HWDATA[8*i +: 8];
  end

  // Data-phase response, side effects, and capture of the next address phase
  always_comb begin
    state_d   = state_q;
    dph_d     = dph_q;
    con_d     = con_q;
    write_d   = write_q;
    size_d    = size_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    ram_we    = 1'b0;
    push      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!dph_q) begin
          done = 1'b1;
        end else if (con_q) begin
          if (write_q && full) begin
            // A full FIFO always stalls at least one cycle, even with a pop now
            HREADYOUT = 1'b0;
            state_d   = CONSTALL;
            dph_d     = 1'b0;
          end else begin
            push   = write_q;
            HRDATA = write_q ? 32'h0 : con_stat;
            done   = 1'b1;
          end
        end else begin
          ram_we = write_q;
          HRDATA = write_q ? 32'h0 : ram_word;
          done   = 1'b1;
        end
      end
      RAMWAIT: begin
        if (cnt_q != 4'd0) begin
          HREADYOUT = 1'b0;
          cnt_d     = cnt_q - 4'd1;
        end else begin
          ram_we = write_q;
          HRDATA = write_q ? 32'h0 : ram_word;
          done   = 1'b1;
        end
      end
      CONSTALL: begin
        if (full) begin
          HREADYOUT = 1'b0;
        end else begin
          push = 1'b1;
          done = 1'b1;
        end
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ERR2;
      end
      ERR2: begin
        HRESP = 1'b1;
        done  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      dph_d   = 1'b0;
      if (accept) begin
        addr_d  = HADDR[AW-1:0];
        write_d = HWRITE;
        size_d  = HSIZE[1:0];
        if (bad || !(is_ram || is_con)) begin
          state_d = ERR1;
        end else if (is_ram) begin
          con_d = 1'b0;
          if (WS == 4'd0) begin
            dph_d = 1'b1;
          end else begin
            state_d = RAMWAIT;
            cnt_d   = WS;
          end
        end else begin
          con_d = 1'b1;
          dph_d = 1'b1;
        end
      end
    end
  end

  assign wr_d = wr_q + (CON_LOG2+1)'(push);
  assign rd_d = rd_q + (CON_LOG2+1)'(pop);

  // Control state and FIFO pointers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      dph_q   <= 1'b0;
      con_q   <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      cnt_q   <= 4'd0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      dph_q   <= dph_d;
      con_q   <= con_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // RAM storage, not reset; write gated off by reset state
  always_ff @(posedge HCLK) begin
    if (ram_we) mem_q[idx] <= merged;
  end

  // Console FIFO storage
  always_ff @(posedge HCLK) begin
    if (push) fifo_q[wr_q[CON_LOG2-1:0]] <= push_byte;
  end
endmodule

// File: tb/tb_ahb_sram_con_slave.sv
// Directed bench: zero-wait and two-wait-state instances share one bus driver.
module tb_ahb_sram_con_slave;
  localparam logic [31:0] CON = 32'h40000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        use2 = 1'b0;
  logic        hsel = 1'b0, hwrite = 1'b0, con_ready = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] haddr = 32'h0, hwdata = 32'h0;

  logic        ho0, ho2, hr0, hr2, cv0, cv2;
  logic [31:0] hrd0, hrd2;
  logic [7:0]  cd0, cd2;
  logic        ho, hr;
  logic [31:0] hrd;

  assign ho  = use2 ? ho2 : ho0;
  assign hr  = use2 ? hr2 : hr0;
  assign hrd = use2 ? hrd2 : hrd0;

  always #5 clk = ~clk;

  ahb_sram_con_slave #(.WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel & ~use2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ho0),
    .HRDATA(hrd0), .HREADYOUT(ho0), .HRESP(hr0),
    .con_valid(cv0), .con_data(cd0), .con_ready(con_ready));

  ahb_sram_con_slave #(.WAIT_STATES(2)) dut2 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel & use2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ho2),
    .HRDATA(hrd2), .HREADYOUT(ho2), .HRESP(hr2),
    .con_valid(cv2), .con_data(cd2), .con_ready(1'b0));

  int checks = 0, failures = 0;

  logic [31:0] op_a [8], op_d [8], rd [8];
  logic        op_w [8];
  logic [2:0]  op_s [8];
  int          waits [8], erc [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input int k, input logic [31:0] a, input logic w, input logic [2:0] s,
                    input logic [31:0] d);
    op_a[k] = a; op_w[k] = w; op_s[k] = s; op_d[k] = d;
  endtask

  // Pipelined issue of op[0..n-1]; entered and left at posedge+1
  task automatic bus(input int n);
    int  i = 0, dp = -1, cyc = 0;
    logic rdy;
    for (int k = 0; k < 8; k++) begin waits[k] = 0; erc[k] = 0; rd[k] = 32'hx; end
    while ((i < n || dp >= 0) && cyc < 200) begin
      if (i < n) begin
        hsel = 1'b1; htrans = 2'b10; haddr = op_a[i]; hwrite = op_w[i]; hsize = op_s[i];
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      hwdata = (dp >= 0) ? op_d[dp] : 32'h0;
      @(negedge clk);
      rdy = ho;
      if (dp >= 0) begin
        erc[dp] += int'(hr);
        if (!rdy) waits[dp]++;
        else rd[dp] = hrd;
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        dp = (i < n) ? i : -1;
        if (i < n) i++;
      end
    end
    hsel = 1'b0; htrans = 2'b00;
    if (cyc >= 200) chk("bus_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic drain(input int n, input logic [31:0] exp);
    con_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("drain_valid%0d", k), 32'(cv0), 32'd1);
      chk($sformatf("drain_data%0d", k), 32'(cd0), 32'(exp[8*k +: 8]));
      @(posedge clk); #1;
    end
    con_ready = 1'b0;
    @(negedge clk);
    chk("drain_empty", 32'(cv0), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_ready0", 32'(ho0), 32'd1);
    chk("rst_resp0", 32'(hr0), 32'd0);
    chk("rst_rdata0", hrd0, 32'h0);
    chk("rst_valid", 32'(cv0), 32'd0);
    chk("rst_cdata", 32'(cd0), 32'd0);
    chk("rst_ready2", 32'(ho2), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two wait states: write then read back
    use2 = 1'b1;
    op(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    op(1, 32'h10, 1'b0, 3'd2, 32'h0);
    bus(2);
    chk("ws_wr_waits", 32'(waits[0]), 32'd2);
    chk("ws_rd_waits", 32'(waits[1]), 32'd2);
    chk("ws_rd_data", rd[1], 32'hDEADBEEF);
    chk("ws_wr_rdata", rd[0], 32'h0);
    chk("ws_resp", 32'(erc[0] + erc[1]), 32'd0);

    // Zero wait: lane merges, pipelined, read right after write
    use2 = 1'b0;
    op(0, 32'h20, 1'b1, 3'd2, 32'h11223344);
    op(1, 32'h22, 1'b1, 3'd0, 32'h00AA0000);
    op(2, 32'h20, 1'b1, 3'd1, 32'h00005566);
    op(3, 32'h20, 1'b0, 3'd2, 32'h0);
    bus(4);
    chk("merge_rd", rd[3], 32'h11AA5566);
    chk("zw_waits", 32'(waits[0] + waits[1] + waits[2] + waits[3]), 32'd0);
    chk("zw_resp", 32'(erc[0] + erc[1] + erc[2] + erc[3]), 32'd0);

    // Error responses, then RAM untouched
    op(0, 32'h21, 1'b1, 3'd1, 32'hFFFFFFFF);
    op(1, 32'h1000, 1'b0, 3'd2, 32'h0);
    op(2, 32'h20, 1'b1, 3'd3, 32'hFFFFFFFF);
    op(3, CON + 32'h4, 1'b0, 3'd2, 32'h0);
    op(4, 32'h20, 1'b0, 3'd2, 32'h0);
    bus(5);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("err_waits%0d", k), 32'(waits[k]), 32'd1);
      chk($sformatf("err_resp%0d", k), 32'(erc[k]), 32'd2);
      chk($sformatf("err_rdata%0d", k), rd[k], 32'h0);
    end
    chk("err_ram_kept", rd[4], 32'h11AA5566);
    chk("err_after_waits", 32'(waits[4]), 32'd0);

    // Console: fifth write stalls until one pop
    op(0, CON, 1'b1, 3'd0, 32'h41);
    op(1, CON, 1'b1, 3'd0, 32'h42);
    op(2, CON, 1'b1, 3'd0, 32'h43);
    op(3, CON, 1'b1, 3'd0, 32'h44);
    op(4, CON, 1'b1, 3'd0, 32'h45);
    fork
      bus(5);
      begin
        repeat (8) @(posedge clk); #1;
        con_ready = 1'b1;
        @(posedge clk); #1;
        con_ready = 1'b0;
      end
    join
    chk("con_nostall", 32'(waits[0] + waits[1] + waits[2] + waits[3]), 32'd0);
    chk("con_stall", 32'(waits[4]), 32'd4);
    drain(4, 32'h45444342);

    // Console status and byte-lane selection
    op(0, CON, 1'b1, 3'd0, 32'h00000031);
    op(1, CON + 32'h2, 1'b1, 3'd0, 32'h005A0000);
    op(2, CON, 1'b1, 3'd2, 32'h12345633);
    op(3, CON, 1'b0, 3'd2, 32'h0);
    bus(4);
    chk("con_stat3", rd[3], 32'h00000003);
    op(0, CON, 1'b1, 3'd0, 32'h44);
    op(1, CON, 1'b0, 3'd2, 32'h0);
    bus(2);
    chk("con_stat4", rd[1], 32'h00000104);
    chk("con_stat_waits", 32'(waits[1]), 32'd0);
    drain(4, 32'h44335A31);
    op(0, CON, 1'b1, 3'd0, 32'h77);
    bus(1);
    @(negedge clk);
    chk("con_queued", 32'(cv0), 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a waited write
    use2 = 1'b1;
    op(0, 32'h30, 1'b1, 3'd2, 32'h12345678);
    bus(1);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("mid_wait", 32'(ho2), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(ho2), 32'd1);
    chk("mid_rst_resp", 32'(hr2), 32'd0);
    chk("mid_rst_fifo", 32'(cv0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op(0, 32'h30, 1'b0, 3'd2, 32'h0);
    bus(1);
    chk("mid_rst_ram", rd[0], 32'h12345678);
    chk("mid_rst_rdwaits", 32'(waits[0]), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
